// File: rtl/lod_mult_seq.sv
// ---------------------------------------------------------------------------
// lod_mult_seq
//   Sequential 8x8 unsigned multiplier using Mitchell's logarithmic
//   approximation. A single 8-bit leading-one detector is shared between the
//   two operands. Each operation runs through these steps:
//     accept -> LOD(a) -> LOD(b) -> log-add/antilog -> hold result
//   Valid/ready handshakes are used on both the operand side and the result side.
//
// Parameters
//   ZERO_SKIP : 1 = a zero operand goes straight to DONE with p=0
//               0 = the full sequence runs and the result is forced to 0
//   CNT_W     : width of the delivered-product counter (wraps)
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous reset, active-high
//   in_valid   in   operand pair valid
//   in_ready   out  block can accept operands (IDLE only)
//   a, b       in   8-bit unsigned operands
//   out_valid  out  product valid (DONE only)
//   out_ready  in   sink accepts product
//   p          out  16-bit approximate product
//   op_count   out  number of products delivered
// ---------------------------------------------------------------------------
module lod_mult_seq #(
  parameter int ZERO_SKIP = 1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       a,
  input  logic [7:0]       b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      p,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOD_A = 3'd1;
  localparam logic [2:0] S_LOD_B = 3'd2;
  localparam logic [2:0] S_CALC  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]       state_reg;
  logic [7:0]       a_reg, b_reg;
  logic [2:0]       ka_reg, kb_reg;
  logic [7:0]       xa_reg, xb_reg;
  logic [15:0]      p_reg;
  logic [CNT_W-1:0] op_count_reg;

  // -------------------------------------------------------------------------
  // Shared leading-one detector. It looks at a_reg only while in LOD_A.
  // In every other state it looks at b_reg.
  // -------------------------------------------------------------------------
  logic [7:0] lod_d;
  logic [7:0] lod_hit;   // one-hot marker of the highest set bit
  logic [2:0] lod_k;
  logic [6:0] lod_frac;
  logic [7:0] lod_x;

  assign lod_d = (state_reg == S_LOD_A) ? a_reg : b_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_lod_hit
      if (gi == 7) begin : g_top
        assign lod_hit[gi] = lod_d[gi];
      end else begin : g_low
        assign lod_hit[gi] = lod_d[gi] & ~(|lod_d[7:gi+1]);
      end
    end
  endgenerate

  // Encode the one-hot marker into an index.
  // When d is 0 there is no hit, so k falls out as 0, the same as for d=1.
  always_comb begin
    lod_k = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (lod_hit[i]) begin
        lod_k = lod_k | 3'(i);
      end
    end
  end

  // Shift the bits below the leading one up to the top of a 7-bit fraction.
  // The leading one itself falls off the top.
  assign lod_frac = lod_d[6:0] << (3'd7 - lod_k);
  assign lod_x    = {1'b0, lod_frac};

  // -------------------------------------------------------------------------
  // Log-domain add and antilog.
  // If the fraction sum carries into bit 7, (1+f) already exceeds 2, so the
  // carry acts as an extra power of two and the characteristic is bumped by 1.
  // -------------------------------------------------------------------------
  logic [7:0]  s_sum;
  logic [3:0]  kk_sum;
  logic [22:0] mant;
  logic [15:0] calc_p;

  assign s_sum  = xa_reg + xb_reg;
  assign kk_sum = {1'b0, ka_reg} + {1'b0, kb_reg};
  assign mant   = s_sum[7] ? ({15'd0, s_sum} << (kk_sum + 4'd1))
                           : ({15'd0, 1'b1, s_sum[6:0]} << kk_sum);
  assign calc_p = ((a_reg == 8'd0) || (b_reg == 8'd0)) ? 16'd0 : 16'(mant >> 7);

  // -------------------------------------------------------------------------
  // Control FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      a_reg        <= '0;
      b_reg        <= '0;
      ka_reg       <= '0;
      kb_reg       <= '0;
      xa_reg       <= '0;
      xb_reg       <= '0;
      p_reg        <= '0;
      op_count_reg <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (in_valid) begin
            a_reg <= a;
            b_reg <= b;
            if ((ZERO_SKIP != 0) && ((a == 8'd0) || (b == 8'd0))) begin
              p_reg     <= 16'd0;
              state_reg <= S_DONE;
            end else begin
              state_reg <= S_LOD_A;
            end
          end
        end
        S_LOD_A: begin
          ka_reg    <= lod_k;
          xa_reg    <= lod_x;
          state_reg <= S_LOD_B;
        end
        S_LOD_B: begin
          kb_reg    <= lod_k;
          xb_reg    <= lod_x;
          state_reg <= S_CALC;
        end
        S_CALC: begin
          p_reg     <= calc_p;
          state_reg <= S_DONE;
        end
        S_DONE: begin
          // Going back through IDLE means a new pair is never accepted
          // in the same cycle that the result is delivered.
          if (out_ready) begin
            op_count_reg <= op_count_reg + 1'b1;
            state_reg    <= S_IDLE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_reg == S_IDLE);
  assign out_valid = (state_reg == S_DONE);
  assign p         = p_reg;
  assign op_count  = op_count_reg;

endmodule

// File: tb/tb_lod_mult_seq.sv
// ---------------------------------------------------------------------------
// tb_lod_mult_seq
//   Directed, table-driven bench for lod_mult_seq.
//   Three instances share one set of inputs:
//     d0 : default parameters (ZERO_SKIP=1, CNT_W=16)
//     nz : ZERO_SKIP=0
//     c4 : CNT_W=4, used to observe the counter wrap
//   Expected products and latencies are written out by hand.
// ---------------------------------------------------------------------------
module tb_lod_mult_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] a, b;
  logic       out_ready;

  logic        d0_in_ready, d0_out_valid;
  logic [15:0] d0_p, d0_op_count;
  logic        nz_in_ready, nz_out_valid;
  logic [15:0] nz_p, nz_op_count;
  logic        c4_in_ready, c4_out_valid;
  logic [15:0] c4_p;
  logic [3:0]  c4_op_count;

  always #5 clk = ~clk;

  lod_mult_seq dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d0_in_ready),
    .a(a), .b(b), .out_valid(d0_out_valid), .out_ready(out_ready),
    .p(d0_p), .op_count(d0_op_count)
  );

  lod_mult_seq #(.ZERO_SKIP(0)) dut_nz (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(nz_in_ready),
    .a(a), .b(b), .out_valid(nz_out_valid), .out_ready(out_ready),
    .p(nz_p), .op_count(nz_op_count)
  );

  lod_mult_seq #(.CNT_W(4)) dut_c4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c4_in_ready),
    .a(a), .b(b), .out_valid(c4_out_valid), .out_ready(out_ready),
    .p(c4_p), .op_count(c4_op_count)
  );

  // The instance under test is selected by sel: 0 = d0, 1 = nz.
  logic        sel;
  logic        s_in_ready, s_out_valid;
  logic [15:0] s_p, s_op_count;
  assign s_in_ready  = sel ? nz_in_ready  : d0_in_ready;
  assign s_out_valid = sel ? nz_out_valid : d0_out_valid;
  assign s_p         = sel ? nz_p         : d0_p;
  assign s_op_count  = sel ? nz_op_count  : d0_op_count;

  typedef struct {
    logic [7:0]  va;
    logic [7:0]  vb;
    logic [15:0] ep;
    int          elat;   // edges from accept (inclusive) until out_valid is high
  } vec_t;

  vec_t main_tab [9];
  vec_t nz_tab   [4];

  int          n_vec = 0;
  int          n_bad = 0;
  logic [15:0] exp_cnt [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Called just after an accepting edge.
  // Counts negedges until out_valid rises, giving up after 20.
  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!s_out_valid && lat < 20);
  endtask

  // Called at a negedge. Runs one full operation with out_ready held high.
  task automatic run_op(input logic [7:0] va, input logic [7:0] vb,
                        input logic [15:0] ep, input int elat);
    int wt;
    int lat;
    a = va; b = vb; in_valid = 1'b1; out_ready = 1'b1;
    wt = 0;
    while (!s_in_ready && wt < 20) begin
      @(negedge clk);
      wt++;
    end
    chk("accept_ready", s_in_ready, 1);
    if (!s_in_ready) begin
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_valid(lat);
    chk("latency", lat, elat);
    chk("product", s_p, ep);
    $display("op sel=%0d a=%0d b=%0d p=%0d lat=%0d", sel, va, vb, s_p, lat);
    exp_cnt[sel] = exp_cnt[sel] + 16'd1;
    @(posedge clk);
    @(negedge clk);
    chk("op_count", s_op_count, exp_cnt[sel]);
    chk("valid_drop", s_out_valid, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_cnt[0] = 16'd0;
    exp_cnt[1] = 16'd0;
  endtask

  initial begin
    int lat;
    int acc;

    main_tab[0] = '{8'd3,   8'd3,   16'd8,     4};
    main_tab[1] = '{8'd255, 8'd255, 16'd65024, 4};
    main_tab[2] = '{8'd128, 8'd2,   16'd256,   4};
    main_tab[3] = '{8'd6,   8'd5,   16'd28,    4};
    main_tab[4] = '{8'd1,   8'd1,   16'd1,     4};
    main_tab[5] = '{8'd0,   8'd200, 16'd0,     1};
    main_tab[6] = '{8'd200, 8'd0,   16'd0,     1};
    main_tab[7] = '{8'd255, 8'd1,   16'd255,   4};
    main_tab[8] = '{8'd10,  8'd12,  16'd112,   4};

    nz_tab[0] = '{8'd0,   8'd200, 16'd0,  4};
    nz_tab[1] = '{8'd6,   8'd5,   16'd28, 4};
    nz_tab[2] = '{8'd200, 8'd0,   16'd0,  4};
    nz_tab[3] = '{8'd3,   8'd3,   16'd8,  4};

    sel = 1'b0; rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = 8'd0; b = 8'd0;
    exp_cnt[0] = 16'd0; exp_cnt[1] = 16'd0;

    // Reset state
    do_reset();
    chk("rst_in_ready", d0_in_ready, 1);
    chk("rst_out_valid", d0_out_valid, 0);
    chk("rst_p", d0_p, 0);
    chk("rst_op_count", d0_op_count, 0);

    // Main vectors on the default instance
    for (int i = 0; i < 9; i++) begin
      run_op(main_tab[i].va, main_tab[i].vb, main_tab[i].ep, main_tab[i].elat);
    end

    // Backpressure: hold the result for 10 cycles.
    // A second pair presented meanwhile must be ignored.
    a = 8'd6; b = 8'd5; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_valid(lat);
    chk("bp_latency", lat, 4);
    chk("bp_product", d0_p, 28);
    a = 8'd9; b = 8'd9; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", d0_out_valid, 1);
      chk("bp_hold_p", d0_p, 28);
      chk("bp_hold_in_ready", d0_in_ready, 0);
      chk("bp_hold_count", d0_op_count, exp_cnt[0]);
    end
    $display("op sel=0 a=6 b=5 p=%0d held 10 cycles", d0_p);
    // Release with in_valid still high. The next cycle must be IDLE and no pair is taken yet.
    out_ready = 1'b1;
    @(posedge clk);
    exp_cnt[0] = exp_cnt[0] + 16'd1;
    @(negedge clk);
    chk("bp_rel_in_ready", d0_in_ready, 1);
    chk("bp_rel_valid", d0_out_valid, 0);
    chk("bp_rel_count", d0_op_count, exp_cnt[0]);
    chk("bp_rel_p_kept", d0_p, 28);
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_valid(lat);
    chk("bp_next_latency", lat, 4);
    chk("bp_next_product", d0_p, 80);
    $display("op sel=0 a=9 b=9 p=%0d lat=%0d", d0_p, lat);
    @(posedge clk);
    exp_cnt[0] = exp_cnt[0] + 16'd1;
    @(negedge clk);
    chk("bp_next_count", d0_op_count, exp_cnt[0]);

    // Reset asserted while the block is in LOD_B
    a = 8'd3; b = 8'd3; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);               // accept -> LOD_A
    #1 in_valid = 1'b0;
    @(posedge clk);               // -> LOD_B
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_cnt[0] = 16'd0; exp_cnt[1] = 16'd0;
    chk("midrst_in_ready", d0_in_ready, 1);
    chk("midrst_out_valid", d0_out_valid, 0);
    chk("midrst_p", d0_p, 0);
    chk("midrst_op_count", d0_op_count, 0);
    $display("op sel=0 reset during LOD_B");
    run_op(8'd3, 8'd3, 16'd8, 4);

    // Back-to-back: in_valid held high. One accept is expected every 5 cycles.
    do_reset();
    a = 8'd3; b = 8'd3; in_valid = 1'b1; out_ready = 1'b1;
    acc = 0;
    for (int i = 0; i < 85; i++) begin
      if (d0_in_ready) acc++;
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("b2b_accepts", acc, 17);
    chk("b2b_count16", d0_op_count, 17);
    chk("b2b_count4_wrap", c4_op_count, 1);
    chk("b2b_idle", d0_in_ready, 1);
    chk("b2b_p", c4_p, 8);
    $display("op back-to-back accepts=%0d count16=%0d count4=%0d", acc, d0_op_count, c4_op_count);

    // ZERO_SKIP=0 instance: zero operands take the full sequence
    do_reset();
    sel = 1'b1;
    for (int i = 0; i < 4; i++) begin
      run_op(nz_tab[i].va, nz_tab[i].vb, nz_tab[i].ep, nz_tab[i].elat);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/lod_mult_seq.md
Name: lod_mult_seq

Overview:
- Sequential Mitchell-approximation 8x8 unsigned multiplier controller.
- Time-shares a single 8-bit leading-one detector instance between both operands.
- Sequences LOD on operand a, then operand b, then the log-domain add and antilog shift.
- Sits between an operand source and a result sink; uses valid/ready handshakes on both sides.

Parameters:
- ZERO_SKIP, 1, when 1 a zero operand bypasses the LOD states and completes in 1 cycle; when 0 the full sequence runs and the result is forced to 0.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept operands
- a  input  8  operand a, unsigned
- b  input  8  operand b, unsigned
- out_valid  output  1  product valid
- out_ready  input  1  sink accepts product
- p  output  16  approximate product, unsigned
- op_count  output  CNT_W  number of products delivered (out_valid && out_ready), wraps

Behaviour:
- Reset, while rst=1 at the edge:
  - state=IDLE, in_ready=1, out_valid=0, p=0, op_count=0.
  - All internal registers (a_r, b_r, ka, xa, kb, xb) are cleared.
  - A reset mid-operation drops the operation; no partial result is output.
- LOD semantics for the shared instance (input d, outputs k[2:0], x[7:0]):
  - k = index of the highest set bit of d; k=0 for d=0 or d=1.
  - x = {0, (d[6:0] << (7-k)) truncated to 7 bits}, i.e. 7 fractional bits.
  - The LOD input mux selects a_r in LOD_A and b_r otherwise.
- States:
  - IDLE: in_ready=1. On in_valid, latch a_r=a and b_r=b.
    - If ZERO_SKIP=1 and (a==0 or b==0), go to DONE with p=0.
    - Otherwise go to LOD_A.
  - LOD_A: capture ka, xa from the LOD; go to LOD_B.
  - LOD_B: capture kb, xb; go to CALC.
  - CALC: compute and register p; go to DONE.
  - DONE: out_valid=1 and p held stable.
    - On out_ready, go to IDLE and increment op_count.
    - Otherwise stay in DONE.
- in_ready=1 only in IDLE. Operations never overlap.
- Latency:
  - Normal operations: out_valid is high after the 4th rising edge counting the accepting edge as the 1st (accept, LOD_A, LOD_B, CALC).
  - Zero-skip operations: out_valid is high after the accepting edge.
  - Minimum issue interval is 5 cycles, or 2 cycles for zero-skip.
- CALC arithmetic:
  - s = xa + xb, 8 bits, range 0..254; kk = ka + kb, 4 bits, range 0..14.
  - If s[7]==0: p = ({1, s[6:0]} << kk) >> 7.
  - If s[7]==1: p = (s << (kk+1)) >> 7.
  - Use a 23-bit intermediate, floor (truncate) the shift, and keep the low 16 bits. No overflow is possible; the maximum result is 65024.
  - If a_r==0 or b_r==0 (ZERO_SKIP=0 path), p=0.
- p changes only on the CALC->DONE edge or the zero-skip entry edge. It retains its value in IDLE until the next result.
- in_valid while not in IDLE is ignored; a and b are not sampled.
- out_ready outside DONE is ignored.
- op_count wraps from 2^CNT_W-1 to 0.
- Simultaneous events:
  - rst has priority over every transition.
  - In DONE with out_ready=1 and in_valid=1, the new pair is not accepted that cycle; in_ready goes high the next cycle.

Test Plan:
- Reset then a=3, b=3, out_ready=1 -> p=8, out_valid high exactly 3 cycles after the accept cycle, op_count=1.
- Exactness and accuracy checks:
  - a=255, b=255 -> p=65024.
  - a=128, b=2 -> p=256.
  - a=6, b=5 -> p=28.
  - a=1, b=1 -> p=1.
- Zero operands:
  - a=0, b=200, ZERO_SKIP=1 -> p=0 and out_valid high 1 cycle after accept.
  - Same stimulus with ZERO_SKIP=0 -> p=0 after the full 3-cycle sequence.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> p and out_valid stable, in_ready=0, a second in_valid ignored, op_count unchanged; release -> op_count increments once.
- Reset mid-operation: assert rst in LOD_B -> next cycle state IDLE, in_ready=1, out_valid=0, p=0, op_count=0; a fresh a=3, b=3 then yields p=8.
- Back-to-back: in_valid held high with out_ready=1 -> accepts every 5 cycles. Use CNT_W=4 with 17 ops -> op_count wraps to 1.
